// File: rtl/text_mode_pkg.sv
// Shared text-mode definitions: display geometry, derived cell counts,
// character codes and the console controller state encoding.
package text_mode_pkg;

    // Default glyph and screen geometry in pixels
    localparam int TM_FONT_W   = 10;
    localparam int TM_FONT_H   = 12;
    localparam int TM_SCREEN_W = 640;
    localparam int TM_SCREEN_H = 480;

    // Derived cell geometry for the default build
    localparam int TM_NCW    = TM_SCREEN_W / TM_FONT_W;
    localparam int TM_NCH    = TM_SCREEN_H / TM_FONT_H;
    localparam int TM_NCELLS = TM_NCW * TM_NCH;
    localparam int TM_CI_W   = $clog2(TM_NCELLS);

    // Character codes handled by the console
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } tm_state_t;

endpackage

// File: rtl/cell_addr_calc.sv
// Cell index from cursor coordinates: NCW*cy + cx at CI_W bits.
// Purely combinational so any text-mode writer can share it.
module cell_addr_calc #(
    parameter int NCW  = 64,
    parameter int CX_W = 6,
    parameter int CY_W = 6,
    parameter int CI_W = 12
) (
    input  logic [CX_W-1:0] i_cx,
    input  logic [CY_W-1:0] i_cy,
    output logic [CI_W-1:0] o_addr
);

    assign o_addr = CI_W'(NCW) * CI_W'(i_cy) + CI_W'(i_cx);

endmodule

// File: rtl/text_cursor_ctrl.sv
// Text-mode console controller: consumes a byte stream, tracks the cursor,
// writes the character RAM and sequences full-screen clears.
// Optional macro TEXT_CTRL_AUTOCLEAR_EN: row overflow clears the screen
// instead of wrapping the cursor back to the top row.
module text_cursor_ctrl
    import text_mode_pkg::*;
#(
    parameter int FONT_W   = TM_FONT_W,
    parameter int FONT_H   = TM_FONT_H,
    parameter int SCREEN_W = TM_SCREEN_W,
    parameter int SCREEN_H = TM_SCREEN_H,
    localparam int NCW     = SCREEN_W / FONT_W,
    localparam int NCH     = SCREEN_H / FONT_H,
    localparam int NCELLS  = NCW * NCH,
    localparam int CI_W    = $clog2(NCELLS),
    localparam int CX_W    = $clog2(NCW),
    localparam int CY_W    = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_char,
    input  logic            clr_req,
    output logic            busy,
    output logic            wr_en,
    output logic [CI_W-1:0] wr_addr,
    output logic [7:0]      wr_data,
    output logic [CX_W-1:0] cursor_x,
    output logic [CY_W-1:0] cursor_y
);

    localparam logic [CI_W-1:0] CNT_LAST = CI_W'(NCELLS - 1);
    localparam logic [CX_W-1:0] CX_LAST  = CX_W'(NCW - 1);
    localparam logic [CY_W-1:0] CY_LAST  = CY_W'(NCH - 1);

    tm_state_t       r_state, w_nxt_state;
    logic [CI_W-1:0] r_cnt, w_nxt_cnt;
    logic [CX_W-1:0] r_cx, w_nxt_cx;
    logic [CY_W-1:0] r_cy, w_nxt_cy;
    logic            r_wr_en, w_nxt_wr_en;
    logic [CI_W-1:0] r_wr_addr, w_nxt_wr_addr;
    logic [7:0]      r_wr_data, w_nxt_wr_data;
    logic            r_busy, w_nxt_busy;

    logic            w_idle;
    logic            w_row_step;
    logic [CX_W-1:0] w_wpos_x;
    logic [CI_W-1:0] w_cell_addr;

    // The state flips to IDLE on the edge that registers the last clear
    // write, so gate on the registered busy to keep that cycle closed.
    assign w_idle   = (r_state == ST_IDLE) && !r_busy;
    assign in_ready = w_idle && !clr_req;

    // Backspace writes at the column it moves back to; everything else
    // writes at the current cursor.
    assign w_wpos_x = (in_char == CH_BS && r_cx != '0) ? r_cx - 1'b1 : r_cx;

    cell_addr_calc #(
        .NCW  (NCW),
        .CX_W (CX_W),
        .CY_W (CY_W),
        .CI_W (CI_W)
    ) u_addr (
        .i_cx   (w_wpos_x),
        .i_cy   (r_cy),
        .o_addr (w_cell_addr)
    );

    // Next-state, cursor and write-port decode
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_cx      = r_cx;
        w_nxt_cy      = r_cy;
        w_nxt_wr_en   = 1'b0;
        w_nxt_wr_addr = r_wr_addr;
        w_nxt_wr_data = r_wr_data;
        w_nxt_busy    = 1'b0;
        w_row_step    = 1'b0;

        if (r_state == ST_CLEAR) begin
            w_nxt_wr_en   = 1'b1;
            w_nxt_wr_addr = r_cnt;
            w_nxt_wr_data = CH_SPACE;
            w_nxt_busy    = 1'b1;
            if (r_cnt == CNT_LAST) begin
                w_nxt_cnt   = '0;
                w_nxt_cx    = '0;
                w_nxt_cy    = '0;
                w_nxt_state = ST_IDLE;
            end else begin
                w_nxt_cnt = r_cnt + 1'b1;
            end
        end else if (w_idle) begin
            if (clr_req) begin
                w_nxt_state = ST_CLEAR;
            end else if (in_valid) begin
                case (in_char)
                    CH_LF: begin
                        w_nxt_cx   = '0;
                        w_row_step = 1'b1;
                    end
                    CH_CR: w_nxt_cx = '0;
                    CH_BS: begin
                        if (r_cx != '0) begin
                            w_nxt_cx      = w_wpos_x;
                            w_nxt_wr_en   = 1'b1;
                            w_nxt_wr_addr = w_cell_addr;
                            w_nxt_wr_data = CH_SPACE;
                        end
                    end
                    CH_FF: w_nxt_state = ST_CLEAR;
                    default: begin
                        if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                            w_nxt_wr_en   = 1'b1;
                            w_nxt_wr_addr = w_cell_addr;
                            w_nxt_wr_data = in_char;
                            if (r_cx == CX_LAST) begin
                                w_nxt_cx   = '0;
                                w_row_step = 1'b1;
                            end else begin
                                w_nxt_cx = r_cx + 1'b1;
                            end
                        end
                    end
                endcase

                if (w_row_step) begin
                    if (r_cy == CY_LAST) begin
                        w_nxt_cy = '0;
`ifdef TEXT_CTRL_AUTOCLEAR_EN
                        w_nxt_state = ST_CLEAR;
`endif
                    end else begin
                        w_nxt_cy = r_cy + 1'b1;
                    end
                end
            end
        end
    end

    // FSM state register; reset always lands in CLEAR to blank the screen
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_CLEAR;
        else     r_state <= w_nxt_state;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_nxt_cnt;
            r_cx      <= w_nxt_cx;
            r_cy      <= w_nxt_cy;
            r_wr_en   <= w_nxt_wr_en;
            r_wr_addr <= w_nxt_wr_addr;
            r_wr_data <= w_nxt_wr_data;
            r_busy    <= w_nxt_busy;
        end
    end

    assign busy     = r_busy;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: clears, printable/control bytes,
// row overflow, clear-request arbitration and reset mid-clear.
module tb_text_cursor_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        clr_req;
    logic        busy;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  cursor_x;
    logic [5:0]  cursor_y;

    int n_vec = 0;
    int n_err = 0;
    logic last_rdy;

    text_cursor_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for a single edge; caller samples at the returned negedge
    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_char  = c;
        #1 last_rdy = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic put_n(input int n, input logic [7:0] c);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_char  = c;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_cur(input string tag, input int x, input int y);
        chk({tag, "_cx"}, 32'(cursor_x), 32'(x));
        chk({tag, "_cy"}, 32'(cursor_y), 32'(y));
    endtask

    task automatic chk_rst_state(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_addr"}, 32'(wr_addr), 0);
        chk({tag, "_data"}, 32'(wr_data), 0);
        chk({tag, "_rdy"}, 32'(in_ready), 0);
        chk_cur(tag, 0, 0);
    endtask

    // Follow a clear from its start; optionally pulse clr_req at write
    // index poke, or stop early after stop_at writes (for a mid-clear reset).
    task automatic check_clear(input string tag, input int poke, input int stop_at);
        int idx = 0;
        int bad = 0;
        int waitc = 0;
        while (!busy && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_start"}, 32'(busy), 1);
        while (busy && idx < 3000) begin
            if (wr_en !== 1'b1 || wr_addr !== 12'(idx) || wr_data !== 8'h20 || in_ready !== 1'b0)
                bad++;
            if (idx == poke) clr_req = 1'b1;
            idx++;
            if (idx == stop_at) break;
            @(negedge clk);
            clr_req = 1'b0;
        end
        chk({tag, "_bad_cycles"}, 32'(bad), 0);
        if (stop_at < 0) begin
            chk({tag, "_len"}, 32'(idx), 2560);
            chk({tag, "_end_wr_en"}, 32'(wr_en), 0);
            chk({tag, "_end_rdy"}, 32'(in_ready), 1);
            chk_cur({tag, "_end"}, 0, 0);
        end
    endtask

    initial begin
        int bad;
        int gaps;
        rst = 1'b1;
        in_valid = 1'b0;
        in_char = 8'h00;
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst_state("reset");

        // Power-up clear
        rst = 1'b0;
        check_clear("clr0", -1, -1);

        // First printable
        send(8'h41);
        chk("A_rdy", 32'(last_rdy), 1);
        chk("A_wr_en", 32'(wr_en), 1);
        chk("A_addr", 32'(wr_addr), 0);
        chk("A_data", 32'(wr_data), 32'h41);
        chk_cur("A", 1, 0);
        @(negedge clk);
        chk("A_pulse", 32'(wr_en), 0);

        // CR back to column 0, then a full row back to back
        send(8'h0D);
        chk("CR0_wr_en", 32'(wr_en), 0);
        chk_cur("CR0", 0, 0);
        bad = 0;
        gaps = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_char  = 8'h30 + 8'(i % 10);
            #1 if (in_ready !== 1'b1) gaps++;
            @(negedge clk);
            if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 8'h30 + 8'(i % 10)) bad++;
        end
        in_valid = 1'b0;
        chk("row_gaps", 32'(gaps), 0);
        chk("row_bad", 32'(bad), 0);
        chk_cur("row", 0, 1);

        // Move to (5,3) and backspace
        put_n(2, 8'h0A);
        put_n(5, 8'h62);
        chk_cur("pos53", 5, 3);
        send(8'h08);
        chk("BS_wr_en", 32'(wr_en), 1);
        chk("BS_addr", 32'(wr_addr), 196);
        chk("BS_data", 32'(wr_data), 32'h20);
        chk_cur("BS", 4, 3);
        send(8'h71);
        chk("q_addr", 32'(wr_addr), 196);
        send(8'h0A);
        chk("LF_wr_en", 32'(wr_en), 0);
        chk_cur("LF", 0, 4);

        // CR, BS at column 0, unknown control byte
        send(8'h78);
        chk_cur("x", 1, 4);
        send(8'h0D);
        chk("CR_wr_en", 32'(wr_en), 0);
        chk_cur("CR", 0, 4);
        send(8'h08);
        chk("BS0_wr_en", 32'(wr_en), 0);
        chk_cur("BS0", 0, 4);
        send(8'h01);
        chk("ctl_wr_en", 32'(wr_en), 0);
        chk_cur("ctl", 0, 4);

        // Last cell and row overflow
        put_n(35, 8'h0A);
        put_n(63, 8'h63);
        chk_cur("pos6339", 63, 39);
        send(8'h5A);
        chk("last_wr_en", 32'(wr_en), 1);
        chk("last_addr", 32'(wr_addr), 2559);
        chk("last_data", 32'(wr_data), 32'h5A);
        chk_cur("last", 0, 0);
`ifdef TEXT_CTRL_AUTOCLEAR_EN
        check_clear("autoclr", -1, -1);
`else
        @(negedge clk);
        chk("wrap_busy", 32'(busy), 0);
        chk("wrap_wr_en", 32'(wr_en), 0);
        chk("wrap_rdy", 32'(in_ready), 1);
`endif

        // Form feed clear; a clr_req mid-clear must not restart it
        send(8'h0C);
        chk("FF_wr_en", 32'(wr_en), 0);
        chk("FF_rdy", 32'(in_ready), 0);
        check_clear("ffclr", 500, -1);

        // clr_req beats a simultaneous byte; the held byte lands after the clear
        clr_req  = 1'b1;
        in_valid = 1'b1;
        in_char  = 8'h42;
        #1 chk("arb_rdy", 32'(in_ready), 0);
        @(negedge clk);
        clr_req = 1'b0;
        chk("arb_wr_en", 32'(wr_en), 0);
        check_clear("arbclr", -1, -1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("B_wr_en", 32'(wr_en), 1);
        chk("B_addr", 32'(wr_addr), 0);
        chk("B_data", 32'(wr_data), 32'h42);
        chk_cur("B", 1, 0);

        // Reset at clear count 1000, then a full clear from address 0
        send(8'h0C);
        check_clear("midclr", -1, 1000);
        rst = 1'b1;
        @(negedge clk);
        chk_rst_state("midrst");
        rst = 1'b0;
        check_clear("clr_after_rst", -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
